// File: rtl/i2s_rx_pkg.sv
// I2S receive core: shared types and constants.
// Used by the deserialiser and its edge detector.
package i2s_rx_pkg;

    typedef enum logic [1:0] {
        S_PRIME = 2'd0,
        S_WAIT  = 2'd1,
        S_SHIFT = 2'd2,
        S_SKIP  = 2'd3
    } state_e;

    localparam logic CH_LEFT  = 1'b0;
    localparam logic CH_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_rx_deser_edge.sv
// I2S receive core: SCK rise and WS transition detection.
// History registers are updated every cycle regardless of enable.
module i2s_edge_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sck_i,
    input  logic ws_i,
    output logic sck_rise,
    output logic ws_edge
);

    logic sck_q;
    logic ws_q;

    assign sck_rise = sck_i & ~sck_q;
    assign ws_edge  = sck_rise & (ws_i ^ ws_q);

    // previous SCK level every cycle, WS level captured on each rise
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_q <= 1'b0;
            ws_q  <= 1'b0;
        end else begin
            sck_q <= sck_i;
            if (sck_rise) begin
                ws_q <= ws_i;
            end
        end
    end

endmodule

// File: rtl/i2s_rx_deser.sv
// I2S receive core: Philips-I2S serial-to-parallel stage.
// Emits each completed left/right word, left-aligned, with a valid pulse.
module i2s_rx_deser
    import i2s_rx_pkg::*;
#(
    parameter int DATA_W = 24
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              sck_i,
    input  logic              ws_i,
    input  logic              sd_i,
    output logic [DATA_W-1:0] data_o,
    output logic              ch_o,
    output logic              valid_o
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DATA_W);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    state_e            state_q;
    state_e            state_d;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [CW-1:0]     cnt_inc;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic [DATA_W-1:0] shreg_in;
    logic              cur_ch_q;
    logic              cur_ch_d;
    logic              ws_ch;
    logic              sck_rise;
    logic              ws_edge_raw;
    logic              ws_edge;
    logic              emit;
    logic [DATA_W-1:0] emit_data;

    i2s_edge_detect u_edge (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .sck_i    (sck_i),
        .ws_i     (ws_i),
        .sck_rise (sck_rise),
        .ws_edge  (ws_edge_raw)
    );

    // the first rise after reset only primes WS history
    assign ws_edge  = ws_edge_raw & (state_q != S_PRIME);
    assign ws_ch    = ws_i ? CH_RIGHT : CH_LEFT;
    assign shreg_in = {shreg_q[DATA_W-2:0], sd_i};
    assign cnt_inc  = cnt_q + CNT_ONE;

    // state and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_PRIME;
            cnt_q    <= '0;
            shreg_q  <= '0;
            cur_ch_q <= CH_LEFT;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            cur_ch_q <= cur_ch_d;
        end
    end

    // next state: moves only on SCK rises, enable low parks in S_WAIT
    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = S_WAIT;
        end else if (sck_rise) begin
            unique case (state_q)
                S_PRIME: state_d = S_WAIT;
                S_WAIT:  if (ws_edge) state_d = S_SHIFT;
                S_SHIFT: begin
                    if (!ws_edge && cnt_inc == CNT_MAX) begin
                        state_d = S_SKIP;
                    end
                end
                S_SKIP:  if (ws_edge) state_d = S_SHIFT;
            endcase
        end
    end

    // datapath updates and emit decision
    always_comb begin
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        cur_ch_d  = cur_ch_q;
        emit      = 1'b0;
        emit_data = shreg_in;
        if (!en_i) begin
            cnt_d = '0;
        end else if (sck_rise) begin
            unique case (state_q)
                S_PRIME: ;
                S_WAIT, S_SKIP: begin
                    if (ws_edge) begin
                        cnt_d    = '0;
                        shreg_d  = '0;
                        cur_ch_d = ws_ch;
                    end
                end
                S_SHIFT: begin
                    if (ws_edge) begin
                        // this bit closes the old slot; left-align it
                        emit      = 1'b1;
                        emit_data = shreg_in << (CNT_MAX - cnt_inc);
                        cnt_d     = '0;
                        shreg_d   = '0;
                        cur_ch_d  = ws_ch;
                    end else begin
                        shreg_d = shreg_in;
                        cnt_d   = cnt_inc;
                        emit    = (cnt_inc == CNT_MAX);
                    end
                end
            endcase
        end
    end

    // registered outputs: one-cycle valid, word and channel hold
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o  <= '0;
            ch_o    <= CH_LEFT;
            valid_o <= 1'b0;
        end else begin
            valid_o <= emit;
            if (emit) begin
                data_o <= emit_data;
                ch_o   <= cur_ch_q;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Bench for i2s_rx_deser: slot-level reference model.
// Expected words come from slot tables, not from bit-level state.
module tb_i2s_rx_deser;

    localparam int W = 24;

    logic         clk   = 1'b0;
    logic         rst_i = 1'b1;
    logic         en_i  = 1'b1;
    logic         sck_i = 1'b0;
    logic         ws_i  = 1'b0;
    logic         sd_i  = 1'b0;
    logic [W-1:0] data_o;
    logic         ch_o;
    logic         valid_o;

    i2s_rx_deser #(.DATA_W(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .sck_i   (sck_i),
        .ws_i    (ws_i),
        .sd_i    (sd_i),
        .data_o  (data_o),
        .ch_o    (ch_o),
        .valid_o (valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         ch;
        int           r;
        int           a;
    } rec_t;

    int   n_pass   = 0;
    int   n_chk    = 0;
    int   rise_cnt = 0;
    int   age      = 0;
    logic sck_prev = 1'b0;
    rec_t got[$];

    int          s_len[$];
    logic        s_ch[$];
    logic [63:0] s_dat[$];

    // clocks elapsed since SCK went high
    always @(posedge clk) begin
        if (sck_i && !sck_prev) age = 1;
        else age = age + 1;
        sck_prev = sck_i;
    end

    // capture every valid cycle
    always @(negedge clk) begin
        if (valid_o === 1'b1)
            got.push_back('{data_o, ch_o, rise_cnt, age});
    end

    task automatic chk(string tag, logic [63:0] obs,
                       logic [63:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic pulse_reset(string tag);
        @(negedge clk);
        rst_i = 1'b1;
        sck_i = 1'b0;
        @(negedge clk);
        chk({tag, "_data"}, 64'(data_o), 64'd0);
        chk({tag, "_ch"}, 64'(ch_o), 64'd0);
        chk({tag, "_valid"}, 64'(valid_o), 64'd0);
        rst_i = 1'b0;
    endtask

    task automatic drive_rise(logic w, logic d);
        @(negedge clk);
        ws_i = w;
        sd_i = d;
        repeat (2) @(negedge clk);
        sck_i = 1'b1;
        rise_cnt++;
        repeat (3) @(negedge clk);
        sck_i = 1'b0;
    endtask

    task automatic add_slot(logic c, int len, logic [63:0] d);
        s_ch.push_back(c);
        s_len.push_back(len);
        s_dat.push_back(d);
    endtask

    // dk: 0 none, 1 enable drop, 2 reset; applied before rise dr
    task automatic run_phase(string name, int dr, int dk);
        logic        wsq[$];
        logic        sdq[$];
        rec_t        expq[$];
        int          total;
        int          s;
        int          e;
        int          n;
        logic        ok;
        logic [63:0] w;
        wsq.delete();
        sdq.delete();
        for (int k = 0; k < s_len.size(); k++) begin
            for (int b = s_len[k] - 1; b >= 0; b--) begin
                wsq.push_back(s_ch[k]);
                sdq.push_back(s_dat[k][b]);
            end
        end
        total = wsq.size();
        en_i = 1'b1;
        pulse_reset({name, "_rst"});
        got.delete();
        rise_cnt = 0;
        for (int i = 0; i < total; i++) begin
            if (i == dr && dk == 1) begin
                @(negedge clk);
                en_i = 1'b0;
                repeat (5) @(negedge clk);
                en_i = 1'b1;
            end
            if (i == dr && dk == 2)
                pulse_reset({name, "_midrst"});
            drive_rise(wsq[i],
                       (i == 0) ? 1'($urandom) : sdq[i-1]);
        end
        repeat (8) @(negedge clk);
        // reference: one word per slot that starts on a seen WS edge
        s = 0;
        expq.delete();
        for (int k = 0; k < s_len.size(); k++) begin
            n = (s_len[k] < W) ? s_len[k] : W;
            e = s + n;
            ok = (s >= 1) && (e < total);
            if (dk != 0 && s < dr && e >= dr) ok = 1'b0;
            if (dk == 2 && s == dr) ok = 1'b0;
            if (s_len[k] >= W)
                w = s_dat[k] >> (s_len[k] - W);
            else
                w = s_dat[k] << (W - s_len[k]);
            if (ok)
                expq.push_back('{w[W-1:0], s_ch[k], e + 1, 1});
            s = s + s_len[k];
        end
        chk({name, "_count"}, 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++) begin
            chk({name, "_data"}, 64'(got[i].d), 64'(expq[i].d));
            chk({name, "_ch"}, 64'(got[i].ch), 64'(expq[i].ch));
            chk({name, "_rise"}, 64'(got[i].r), 64'(expq[i].r));
            chk({name, "_lat"}, 64'(got[i].a), 64'(expq[i].a));
        end
        s_len.delete();
        s_ch.delete();
        s_dat.delete();
    endtask

    initial begin
        int          len;
        int          dr;
        int          dk;
        int          tot;
        logic        c;
        logic [63:0] d;

        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        chk("por_data", 64'(data_o), 64'd0);
        chk("por_valid", 64'(valid_o), 64'd0);

        // 32-bit slots, truncated to 24
        add_slot(1'b1, 32, 64'h0000_0000_DEAD_BEEF);
        add_slot(1'b0, 32, 64'h0000_0000_A5A5_A500);
        add_slot(1'b1, 32, 64'h0000_0000_1234_5600);
        add_slot(1'b0, 32, 64'h0000_0000_0000_0000);
        add_slot(1'b1, 32, 64'h0000_0000_FFFF_FFFF);
        run_phase("s32", -1, 0);

        // 16-bit slots, zero padded
        add_slot(1'b1, 16, 64'h1234);
        add_slot(1'b0, 16, 64'hBEEF);
        add_slot(1'b1, 16, 64'h0F0F);
        add_slot(1'b0, 16, 64'h5555);
        run_phase("s16", -1, 0);

        // 24-bit slots, LSB on the WS-edge rise
        add_slot(1'b1, 24, 64'h0ABCDE);
        add_slot(1'b0, 24, 64'h800001);
        add_slot(1'b1, 24, 64'h7FFFFE);
        add_slot(1'b0, 24, 64'h000000);
        run_phase("s24", -1, 0);

        // WS stuck high: nothing ever emitted
        add_slot(1'b1, 100, {$urandom, $urandom} & 64'hF_FFFF_FFFF_FFFF);
        run_phase("stuck", -1, 0);
        chk("stuck_hold", 64'(data_o), 64'd0);

        // enable drop in the middle of a left word
        add_slot(1'b1, 32, 64'h11111111);
        add_slot(1'b0, 32, 64'hCAFEF00D);
        add_slot(1'b1, 32, 64'h76543210);
        add_slot(1'b0, 32, 64'h89ABCDEF);
        add_slot(1'b1, 32, 64'h0);
        run_phase("endrop", 42, 2 - 1);

        // reset in the middle of right word 0x654321
        add_slot(1'b1, 24, 64'h111111);
        add_slot(1'b0, 24, 64'hC0FFEE);
        add_slot(1'b1, 24, 64'h654321);
        add_slot(1'b0, 24, 64'h13579B);
        add_slot(1'b1, 24, 64'h2468AC);
        add_slot(1'b0, 24, 64'h0);
        run_phase("midrst", 56, 2);

        // random slot lengths, data and one optional disruption
        for (int p = 0; p < 5; p++) begin
            c = 1'($urandom);
            tot = 0;
            for (int k = 0; k < 8; k++) begin
                len = $urandom_range(8, 40);
                d = {$urandom, $urandom} & ((64'd1 << len) - 64'd1);
                add_slot(c, len, d);
                c = ~c;
                tot = tot + len;
            end
            dk = $urandom_range(0, 2);
            dr = $urandom_range(2, tot - 1);
            run_phase("rand", dr, dk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
